// File: rtl/histogram_engine_pkg.sv
// histogram_engine_pkg: shared FSM states and constants for the histogram engine
package histogram_engine_pkg;
   typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_ACCUM, ST_DRAIN, ST_READOUT} state_t;
   localparam int DRAIN_CYCLES = 2;
   function automatic int bin_width(input int pixel_w, input int bin_shift);
      return pixel_w - bin_shift;
   endfunction
endpackage

// File: rtl/histogram_engine_ram.sv
// histogram_engine_ram: simple dual-port bin RAM, sync read, read-old on collision
module histogram_engine_ram #(
   parameter int AW = 10,
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          re,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rdata,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd
);
   logic [DW-1:0] mem [2**AW];
   // write and registered read share the edge, so a colliding read sees the old word
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rdata <= mem[ra];
   end
endmodule

// File: rtl/histogram_engine.sv
// histogram_engine: streaming per-frame pixel histogram with clear-on-read readout
module histogram_engine
   import histogram_engine_pkg::*;
#(
   parameter int PIXEL_W   = 10,
   parameter int BIN_SHIFT = 0,
   parameter int COUNT_W   = 24,
   localparam int BIN_W    = bin_width(PIXEL_W, BIN_SHIFT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIXEL_W-1:0] pixel,
   input  logic               pixel_valid,
   input  logic               frame_start,
   input  logic               frame_end,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [BIN_W-1:0]   rd_bin,
   output logic [COUNT_W-1:0] rd_data,
   output logic               rd_last,
   output logic               busy,
   output logic               frame_done,
   output logic               sat_flag,
   output logic               drop_flag
);
   localparam logic [COUNT_W-1:0] CNT_MAX    = '1;
   localparam logic [BIN_W:0]     PTR_ONE    = 1;
   localparam logic [BIN_W:0]     DRAIN_LAST = (BIN_W+1)'(DRAIN_CYCLES - 1);
   state_t state_q, state_d;
   logic [BIN_W:0] ptr_q, ptr_d;
   logic pend_q, pend_d, frame_done_q, frame_done_d, sat_q, sat_d, drop_q, drop_d;
   logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d, f_v_q, f_v_d;
   logic [BIN_W-1:0] s1_bin_q, s1_bin_d, s2_bin_q, s2_bin_d, s3_bin_q, s3_bin_d, f_bin_q, f_bin_d;
   logic [COUNT_W-1:0] s2_cnt_q, s2_cnt_d, s3_cnt_q, s3_cnt_d;
   logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
   logic [BIN_W-1:0] rd_bin_q, rd_bin_d;
   logic [COUNT_W-1:0] rd_data_q, rd_data_d;
   logic [BIN_W-1:0] pix_bin, ram_ra, ram_wa;
   logic [COUNT_W-1:0] ram_rd, ram_wd, old_cnt;
   logic ram_re, ram_we, issue, o_adv, acc;
   assign pix_bin = BIN_W'(pixel >> BIN_SHIFT);
   histogram_engine_ram #(.AW(BIN_W), .DW(COUNT_W)) u_ram (
      .clk(clk), .re(ram_re), .ra(ram_ra), .rdata(ram_rd), .we(ram_we), .wa(ram_wa), .wd(ram_wd)
   );
   // RMW pipeline with two-deep bypass, readout prefetch/output stages and RAM port muxing
   always_comb begin
      o_adv = !rd_valid_q || rd_ready;
      acc = rd_valid_q && rd_ready;
      issue = state_q == ST_READOUT && !ptr_q[BIN_W] && (!f_v_q || o_adv);
      old_cnt = (s2_v_q && s2_bin_q == s1_bin_q) ? s2_cnt_q :
                (s3_v_q && s3_bin_q == s1_bin_q) ? s3_cnt_q : ram_rd;
      s1_v_d = state_q == ST_ACCUM && pixel_valid;
      s1_bin_d = pix_bin;
      s2_v_d = s1_v_q;
      s2_bin_d = s1_bin_q;
      s2_cnt_d = old_cnt == CNT_MAX ? CNT_MAX : old_cnt + COUNT_W'(1);
      s3_v_d = s2_v_q;
      s3_bin_d = s2_bin_q;
      s3_cnt_d = s2_cnt_q;
      f_v_d = issue || (f_v_q && !o_adv);
      f_bin_d = issue ? ptr_q[BIN_W-1:0] : f_bin_q;
      rd_valid_d = o_adv ? f_v_q : rd_valid_q;
      rd_bin_d = (o_adv && f_v_q) ? f_bin_q : rd_bin_q;
      rd_data_d = (o_adv && f_v_q) ? ram_rd : rd_data_q;
      rd_last_d = o_adv ? (f_v_q && f_bin_q == '1) : rd_last_q;
      ram_re = s1_v_d || issue;
      ram_ra = state_q == ST_ACCUM ? pix_bin : ptr_q[BIN_W-1:0];
      ram_we = state_q == ST_CLEAR || s2_v_q || acc;
      ram_wa = state_q == ST_CLEAR ? ptr_q[BIN_W-1:0] : s2_v_q ? s2_bin_q : rd_bin_q;
      ram_wd = s2_v_q ? s2_cnt_q : '0;
   end
   // frame FSM, shared sweep/drain/issue pointer and sticky flags
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      pend_d = 1'b0;
      frame_done_d = 1'b0;
      sat_d = sat_q || (s1_v_q && old_cnt == CNT_MAX);
      drop_d = drop_q || (pixel_valid && state_q != ST_ACCUM);
      case (state_q)
         ST_CLEAR: begin
            ptr_d = ptr_q[BIN_W-1:0] == '1 ? '0 : ptr_q + PTR_ONE;
            state_d = ptr_q[BIN_W-1:0] == '1 ? ST_IDLE : ST_CLEAR;
         end
         ST_IDLE: if (frame_start) begin
            state_d = ST_ACCUM;
            pend_d = frame_end;
            sat_d = 1'b0;
            drop_d = pixel_valid;
         end
         ST_ACCUM: state_d = (frame_end || pend_q) ? ST_DRAIN : ST_ACCUM;
         ST_DRAIN: begin
            ptr_d = ptr_q == DRAIN_LAST ? '0 : ptr_q + PTR_ONE;
            state_d = ptr_q == DRAIN_LAST ? ST_READOUT : ST_DRAIN;
         end
         ST_READOUT: begin
            ptr_d = ptr_q + (BIN_W+1)'(issue);
            if (acc && rd_last_q) begin
               state_d = ST_IDLE;
               ptr_d = '0;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end
   // state registers; reset aborts any frame and restarts the clear sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         ptr_q <= '0;
         pend_q <= 1'b0;
         frame_done_q <= 1'b0;
         sat_q <= 1'b0;
         drop_q <= 1'b0;
         s1_v_q <= 1'b0;
         s1_bin_q <= '0;
         s2_v_q <= 1'b0;
         s2_bin_q <= '0;
         s2_cnt_q <= '0;
         s3_v_q <= 1'b0;
         s3_bin_q <= '0;
         s3_cnt_q <= '0;
         f_v_q <= 1'b0;
         f_bin_q <= '0;
         rd_valid_q <= 1'b0;
         rd_bin_q <= '0;
         rd_data_q <= '0;
         rd_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         pend_q <= pend_d;
         frame_done_q <= frame_done_d;
         sat_q <= sat_d;
         drop_q <= drop_d;
         s1_v_q <= s1_v_d;
         s1_bin_q <= s1_bin_d;
         s2_v_q <= s2_v_d;
         s2_bin_q <= s2_bin_d;
         s2_cnt_q <= s2_cnt_d;
         s3_v_q <= s3_v_d;
         s3_bin_q <= s3_bin_d;
         s3_cnt_q <= s3_cnt_d;
         f_v_q <= f_v_d;
         f_bin_q <= f_bin_d;
         rd_valid_q <= rd_valid_d;
         rd_bin_q <= rd_bin_d;
         rd_data_q <= rd_data_d;
         rd_last_q <= rd_last_d;
      end
   end
   assign rd_valid = rd_valid_q;
   assign rd_bin = rd_bin_q;
   assign rd_data = rd_data_q;
   assign rd_last = rd_last_q;
   assign busy = state_q == ST_CLEAR || state_q == ST_DRAIN || state_q == ST_READOUT;
   assign frame_done = frame_done_q;
   assign sat_flag = sat_q;
   assign drop_flag = drop_q;
endmodule
